// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - MEM-stage load/store initiator for a word-indexed data RAM
// Sub-word loads are extended here; sub-word stores read-modify-write the containing word.
module mem_access_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH_LOG2 = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic                  resp_err,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_datain,
  output logic                  ram_we,
  output logic                  ram_re,
  input  logic [DATA_WIDTH-1:0] ram_dataout
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t                state_q, state_d;
  logic                  we_q, uns_q, err_q;
  logic [1:0]            size_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q, word_q;
  logic                  accept, req_err;
  logic [DATA_WIDTH-1:0] load_val, merged;
  logic [7:0]            byte_sel;
  logic [15:0]           half_sel;

  assign accept  = req_valid && (state_q == IDLE);
  assign req_err = (req_size == 2'b11)
                || (req_size == 2'b01 && req_addr[0])
                || (req_size == 2'b10 && req_addr[1:0] != 2'b00)
                || (req_addr[ADDR_WIDTH-1:DEPTH_LOG2+2] != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (req_err)                       state_d = DONE;
          else if (req_we && req_size == 2'b10) state_d = WRITE;
          else                               state_d = READ;
        end
      end
      READ:    state_d = we_q ? WRITE : DONE;
      WRITE:   state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  // Request fields are frozen at accept; word_q holds the RAM word read in READ.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
      size_q  <= 2'b00;
      addr_q  <= '0;
      wdata_q <= '0;
      word_q  <= '0;
    end else begin
      if (accept) begin
        we_q    <= req_we;
        uns_q   <= req_unsigned;
        err_q   <= req_err;
        size_q  <= req_size;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
      if (state_q == READ) word_q <= ram_dataout;
    end
  end

  assign byte_sel = word_q[{addr_q[1:0], 3'b000} +: 8];
  assign half_sel = addr_q[1] ? word_q[31:16] : word_q[15:0];

  always_comb begin
    load_val = word_q;
    case (size_q)
      2'b00:   load_val = {{24{~uns_q & byte_sel[7]}}, byte_sel};
      2'b01:   load_val = {{16{~uns_q & half_sel[15]}}, half_sel};
      default: load_val = word_q;
    endcase
  end

  always_comb begin
    merged = word_q;
    case (size_q)
      2'b00: merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
      2'b01: begin
        if (addr_q[1]) merged[31:16] = wdata_q[15:0];
        else           merged[15:0]  = wdata_q[15:0];
      end
      default: merged = wdata_q;
    endcase
  end

  // All outputs decode from registered state so reset drops them without a clock.
  always_comb begin
    req_ready  = (state_q == IDLE);
    resp_valid = (state_q == DONE);
    resp_err   = (state_q == DONE) && err_q;
    resp_rdata = '0;
    ram_re     = (state_q == READ);
    ram_we     = (state_q == WRITE);
    ram_addr   = '0;
    ram_datain = '0;
    if (state_q == DONE && !err_q && !we_q) resp_rdata = load_val;
    if (state_q == READ || state_q == WRITE) ram_addr = {addr_q[ADDR_WIDTH-1:2], 2'b00};
    if (state_q == WRITE) ram_datain = merged;
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - self-checking bench for mem_access_unit
// A request-level model predicts each response, its latency and the RAM traffic.
module tb_mem_access_unit;

  logic        clk, rst_n;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err, ram_we, ram_re;
  logic [31:0] resp_rdata, ram_addr, ram_datain, ram_dataout;

  mem_access_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH_LOG2(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_err(resp_err),
    .resp_rdata(resp_rdata), .ram_addr(ram_addr), .ram_datain(ram_datain),
    .ram_we(ram_we), .ram_re(ram_re), .ram_dataout(ram_dataout)
  );

  logic [31:0] mem [32];
  logic [31:0] ref_mem [32];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign ram_dataout = ram_re ? mem[ram_addr[6:2]] : 32'h0;
  always @(negedge clk) if (ram_we) mem[ram_addr[6:2]] <= ram_datain;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] ld_val(input logic [31:0] w, input logic [31:0] a,
                                         input logic [1:0] sz, input logic uns);
    logic [31:0] v;
    if (sz == 2'd0) begin
      v = (w >> (8 * (a % 4))) % 256;
      if (!uns && v >= 128) v = v - 256;
    end else if (sz == 2'd1) begin
      v = (w >> (16 * ((a / 2) % 2))) % 65536;
      if (!uns && v >= 32768) v = v - 65536;
    end else v = w;
    return v;
  endfunction

  function automatic logic [31:0] st_val(input logic [31:0] w, input logic [31:0] a,
                                         input logic [1:0] sz, input logic [31:0] d);
    logic [31:0] m;
    int sh;
    if (sz == 2'd2) return d;
    sh = (sz == 2'd0) ? 8 * (a % 4) : 16 * ((a / 2) % 2);
    m  = ((sz == 2'd0) ? 32'd255 : 32'd65535) << sh;
    return (w & ~m) | ((d << sh) & m);
  endfunction

  // Model state for the single outstanding request.
  int          cyc = 0, due = 0, re_cnt = 0, we_cnt = 0, hold_cnt = 0;
  bit          pend = 0, exp_err, exp_store, exp_re_n, exp_we_n;
  logic [31:0] exp_rdata, exp_wword, exp_waddr;
  int          exp_idx;
  logic [31:0] last_rdata;
  bit          last_err;
  int          last_re, last_we, last_hold;

  always @(negedge clk) begin
    if (!rst_n) begin
      pend = 0;
      hold_cnt = 0;
    end else begin
      cyc++;
      chk("ram_we_re_exclusive", {31'd0, ram_we & ram_re}, 32'd0);
      chk("resp_valid", {31'd0, resp_valid}, {31'd0, pend && cyc == due});
      if (ram_re) begin
        re_cnt++;
        chk("ram_addr_read", ram_addr, exp_waddr);
      end
      if (ram_we) begin
        we_cnt++;
        chk("ram_addr_write", ram_addr, exp_waddr);
        chk("ram_datain", ram_datain, exp_wword);
      end
      if (!ram_re && !ram_we) chk("ram_bus_idle", ram_addr | ram_datain, 32'd0);
      if (pend && cyc == due) begin
        chk("resp_err", {31'd0, resp_err}, {31'd0, exp_err});
        chk("resp_rdata", resp_rdata, exp_rdata);
        chk("ram_re_cycles", re_cnt, {31'd0, exp_re_n});
        chk("ram_we_cycles", we_cnt, {31'd0, exp_we_n});
        if (exp_store) ref_mem[exp_idx] = exp_wword;
        last_rdata = resp_rdata;
        last_err   = resp_err;
        last_re    = re_cnt;
        last_we    = we_cnt;
        pend = 0;
      end
      if (req_valid && !req_ready) hold_cnt++;
      if (req_valid && req_ready) begin
        logic [31:0] a, w;
        a = req_addr;
        exp_err = (req_size == 2'd3) || (req_size == 2'd1 && a % 2 != 0)
               || (req_size == 2'd2 && a % 4 != 0) || (a >= 128);
        exp_idx   = int'(a % 128) / 4;
        w         = ref_mem[exp_idx];
        exp_rdata = (!exp_err && !req_we) ? ld_val(w, a, req_size, req_unsigned) : 32'd0;
        exp_store = !exp_err && req_we;
        exp_wword = st_val(w, a, req_size, req_wdata);
        exp_waddr = a - a % 4;
        exp_re_n  = !exp_err && (!req_we || req_size != 2'd2);
        exp_we_n  = exp_store;
        due = cyc + (exp_err ? 1 : (!req_we || req_size == 2'd2) ? 2 : 3);
        re_cnt = 0;
        we_cnt = 0;
        last_hold = hold_cnt;
        hold_cnt = 0;
        pend = 1;
      end
    end
  end

  // Caller enters at posedge+1; returns at posedge+1 right after the accept edge.
  task automatic do_req(input bit we, input logic [1:0] sz, input bit uns,
                        input logic [31:0] a, input logic [31:0] d);
    int n;
    req_we = we; req_size = sz; req_unsigned = uns; req_addr = a; req_wdata = d;
    req_valid = 1'b1;
    n = 0;
    while (1) begin
      @(negedge clk);
      if (req_ready) break;
      n++;
      if (n > 20) begin
        chk("accept_timeout", 32'd1, 32'd0);
        break;
      end
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (pend) begin
      @(posedge clk); #1;
      n++;
      if (n > 20) begin
        chk("response_timeout", 32'd1, 32'd0);
        pend = 0;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic run(input bit we, input logic [1:0] sz, input bit uns,
                     input logic [31:0] a, input logic [31:0] d);
    do_req(we, sz, uns, a, d);
    wait_idle();
  endtask

  logic [31:0] err_addr [4] = '{32'h06, 32'h13, 32'h10, 32'h80};
  logic [1:0]  err_size [4] = '{2'd2, 2'd1, 2'd3, 2'd2};

  initial begin
    for (int i = 0; i < 32; i++) begin
      mem[i] = $urandom;
      ref_mem[i] = mem[i];
    end
    req_valid = 0; req_we = 0; req_size = 0; req_unsigned = 0; req_addr = 0; req_wdata = 0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_resp", {29'd0, resp_valid, resp_err, |resp_rdata}, 32'd0);
    chk("rst_ram", {30'd0, ram_we, ram_re} | ram_addr | ram_datain, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    run(1, 2'd2, 0, 32'h10, 32'h800080F0);
    chk("sw_err", {31'd0, last_err}, 32'd0);
    chk("sw_we_cycles", last_we, 32'd1);
    run(0, 2'd0, 0, 32'h10, 32'h0); chk("lb", last_rdata, 32'hFFFFFFF0);
    run(0, 2'd0, 1, 32'h10, 32'h0); chk("lbu", last_rdata, 32'h000000F0);
    run(0, 2'd1, 0, 32'h12, 32'h0); chk("lh", last_rdata, 32'hFFFF8000);
    run(0, 2'd1, 1, 32'h12, 32'h0); chk("lhu", last_rdata, 32'h00008000);

    run(1, 2'd2, 0, 32'h14, 32'h00000105);
    run(1, 2'd0, 0, 32'h15, 32'hFFFFFFAA);
    chk("sb_merge", mem[5], 32'h0000AA05);
    chk("sb_rmw", last_re * 2 + last_we, 32'd3);
    run(1, 2'd1, 0, 32'h16, 32'hABCD1234);
    chk("sh_merge", mem[5], 32'h1234AA05);

    for (int i = 0; i < 4; i++) begin
      run(0, err_size[i], 0, err_addr[i], 32'h0);
      chk("err_flag", {31'd0, last_err}, 32'd1);
      chk("err_no_ram", last_re + last_we, 32'd0);
    end

    do_req(1, 2'd0, 0, 32'h19, 32'h0000005A);
    do_req(0, 2'd2, 0, 32'h18, 32'h0);
    chk("busy_hold_cycles", last_hold, 32'd3);
    wait_idle();
    chk("hold_lw_lane1", (last_rdata >> 8) & 32'hFF, 32'h5A);

    do_req(1, 2'd0, 0, 32'h14, 32'h00000077);
    @(posedge clk); #1;
    chk("in_write", {31'd0, ram_we}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_ram_we", {31'd0, ram_we}, 32'd0);
    chk("abort_outputs", {29'd0, resp_valid, resp_err, ~req_ready} | ram_addr | ram_datain | resp_rdata, 32'd0);
    @(negedge clk); #1;
    chk("abort_word_kept", mem[5], 32'h1234AA05);
    rst_n = 1'b1;
    @(posedge clk); #1;
    run(0, 2'd2, 0, 32'h14, 32'h0);
    chk("after_abort_lw", last_rdata, 32'h1234AA05);

    for (int i = 0; i < 400; i++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 127));
      do_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             a, $urandom);
      if ($urandom_range(0, 3) == 0) wait_idle();
    end
    wait_idle();

    for (int i = 0; i < 32; i++) chk("final_mem", mem[i], ref_mem[i]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
